writeback_unit: RTL and testbench

//  Final stage of the sequential RV64 core: owns the write port of the register file
//  (drives RegWrite/rd/write_data). Accepts retiring instructions via valid/ready,

---
 rtl/writeback_unit.sv | 134 +++++++++++++
 tb/tb_writeback_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// writeback_unit: register-file write stage with valid/ready intake, load wait with timeout,
// and load byte extraction/extension.
module writeback_unit #(
    parameter int XLEN        = 64,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_reg_write,
    input  logic            in_mem_to_reg,
    input  logic [2:0]      in_funct3,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            RegWrite,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] write_data,
    output logic            retire,
    output logic            err,
    output logic            pend_valid,
    output logic [4:0]      pend_rd
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_MEM, RETIRE} state_t;

    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [4:0] lrd, lrd_n, rd_n;
    logic [2:0] lf3, lf3_n, loff, loff_n;
    logic reg_write_n, retire_n, err_n, accept, illegal;
    logic [XLEN-1:0] write_data_n, shifted;

    function automatic logic [XLEN-1:0] ext(input logic [2:0] f, input logic [XLEN-1:0] v);
        case (f)
            3'd0:    ext = {{(XLEN-8){v[7]}}, v[7:0]};
            3'd1:    ext = {{(XLEN-16){v[15]}}, v[15:0]};
            3'd2:    ext = {{(XLEN-32){v[31]}}, v[31:0]};
            3'd4:    ext = {{(XLEN-8){1'b0}}, v[7:0]};
            3'd5:    ext = {{(XLEN-16){1'b0}}, v[15:0]};
            3'd6:    ext = {{(XLEN-32){1'b0}}, v[31:0]};
            default: ext = v;
        endcase
    endfunction

    assign in_ready   = state != WAIT_MEM;
    assign pend_valid = state == WAIT_MEM;
    assign pend_rd    = pend_valid ? lrd : 5'd0;
    assign accept     = in_valid & in_ready;
    assign shifted    = mem_rdata >> {loff, 3'b000};
    // funct3[1:0] encodes access size; each size needs its low offset bits clear
    assign illegal    = (in_funct3 == 3'b111)
                      | ((in_funct3[1:0] == 2'd1) & in_alu_result[0])
                      | ((in_funct3[1:0] == 2'd2) & |in_alu_result[1:0])
                      | ((in_funct3[1:0] == 2'd3) & |in_alu_result[2:0]);

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        lrd_n        = lrd;
        lf3_n        = lf3;
        loff_n       = loff;
        rd_n         = rd;
        write_data_n = write_data;
        reg_write_n  = 1'b0;
        retire_n     = 1'b0;
        err_n        = 1'b0;
        if (state == WAIT_MEM) begin
            if (mem_rvalid) begin
                state_n      = RETIRE;
                rd_n         = lrd;
                reg_write_n  = lrd != 5'd0;
                write_data_n = ext(lf3, shifted);
                retire_n     = 1'b1;
            end else if (cnt == LIMIT) begin
                state_n  = RETIRE;
                retire_n = 1'b1;
                err_n    = 1'b1;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end else if (accept) begin
            if (in_mem_to_reg && illegal) begin
                state_n  = RETIRE;
                retire_n = 1'b1;
                err_n    = 1'b1;
            end else if (in_mem_to_reg) begin
                state_n = WAIT_MEM;
                cnt_n   = '0;
                lrd_n   = in_rd;
                lf3_n   = in_funct3;
                loff_n  = in_alu_result[2:0];
            end else begin
                state_n      = RETIRE;
                rd_n         = in_rd;
                write_data_n = in_alu_result;
                reg_write_n  = in_reg_write & (in_rd != 5'd0);
                retire_n     = 1'b1;
            end
        end else begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            lrd        <= '0;
            lf3        <= '0;
            loff       <= '0;
            rd         <= '0;
            write_data <= '0;
            RegWrite   <= 1'b0;
            retire     <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            lrd        <= lrd_n;
            lf3        <= lf3_n;
            loff       <= loff_n;
            rd         <= rd_n;
            write_data <= write_data_n;
            RegWrite   <= reg_write_n;
            retire     <= retire_n;
            err        <= err_n;
        end
    end
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed scenarios plus randomized ALU/load traffic against an
// arithmetic model of load extraction, legality and timeout timing.
module tb_writeback_unit;
    logic        clk = 0, reset = 1;
    logic        in_valid = 0, in_ready, in_reg_write = 0, in_mem_to_reg = 0;
    logic [2:0]  in_funct3 = 0;
    logic [4:0]  in_rd = 0, rd, pend_rd;
    logic [63:0] in_alu_result = 0, mem_rdata = 0, write_data;
    logic        mem_rvalid = 0, RegWrite, retire, err, pend_valid;
    int errors = 0, checks = 0;

    writeback_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg), .in_funct3(in_funct3),
        .in_rd(in_rd), .in_alu_result(in_alu_result), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .RegWrite(RegWrite), .rd(rd), .write_data(write_data),
        .retire(retire), .err(err), .pend_valid(pend_valid), .pend_rd(pend_rd)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected load value: take the access-sized field at byte offset, then extend by funct3[2].
    function automatic logic [63:0] load_model(input logic [2:0] f3, input logic [2:0] off, input logic [63:0] data);
        int nb;
        logic [63:0] v, m;
        nb = 1 << f3[1:0];
        v = data >> (8 * off);
        if (nb == 8) return v;
        m = (64'd1 << (8 * nb)) - 64'd1;
        v = v & m;
        if (!f3[2] && v[8*nb-1]) v = v | ~m;
        return v;
    endfunction

    function automatic logic load_legal(input logic [2:0] f3, input logic [2:0] off);
        int nb;
        nb = 1 << f3[1:0];
        return (f3 != 3'b111) && ((int'(off) % nb) == 0);
    endfunction

    // Issues one load and waits (bounded) for retire; lat = cycles from accept to retire visibility.
    task automatic load_txn(input logic [2:0] f3, input logic [4:0] r, input logic [2:0] off,
                            input logic [63:0] data, input int dly, output int lat,
                            output logic o_rw, output logic [4:0] o_rd, output logic [63:0] o_wd,
                            output logic o_err);
        logic [63:0] addr;
        addr = {$urandom, $urandom};
        addr[2:0] = off;
        in_valid = 1; in_mem_to_reg = 1; in_reg_write = 1;
        in_funct3 = f3; in_rd = r; in_alu_result = addr; mem_rdata = data;
        tick;
        in_valid = 0; in_mem_to_reg = 0;
        lat = 1;
        while (!retire && lat < 40) begin
            mem_rvalid = (lat == dly);
            tick;
            mem_rvalid = 0;
            lat++;
        end
        o_rw = RegWrite; o_rd = rd; o_wd = write_data; o_err = err;
    endtask

    task automatic test_reset;
        reset = 1;
        #1;
        checks++; if ({RegWrite, rd, write_data, retire, err, pend_valid, pend_rd} !== '0) begin errors++; $display("FAIL reset_outputs got rw=%b rd=%0d wd=%h ret=%b err=%b pv=%b prd=%0d want all 0", RegWrite, rd, write_data, retire, err, pend_valid, pend_rd); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        tick; tick;
        reset = 0;
        tick;
    endtask

    task automatic test_alu_back_to_back;
        in_valid = 1; in_reg_write = 1; in_mem_to_reg = 0; in_rd = 5; in_alu_result = 64'hA;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0 got %b want 1", in_ready); end
        tick;
        in_rd = 6; in_alu_result = 64'hB;
        checks++; if ({RegWrite, rd, write_data, in_ready} !== {1'b1, 5'd5, 64'hA, 1'b1}) begin errors++; $display("FAIL b2b_first got rw=%b rd=%0d wd=%h rdy=%b want 1/5/a/1", RegWrite, rd, write_data, in_ready); end
        tick;
        in_valid = 0;
        checks++; if ({RegWrite, rd, write_data, retire} !== {1'b1, 5'd6, 64'hB, 1'b1}) begin errors++; $display("FAIL b2b_second got rw=%b rd=%0d wd=%h ret=%b want 1/6/b/1", RegWrite, rd, write_data, retire); end
        tick;
        checks++; if ({RegWrite, retire, in_ready} !== 3'b001) begin errors++; $display("FAIL b2b_idle got rw=%b ret=%b rdy=%b want 0/0/1", RegWrite, retire, in_ready); end
    endtask

    task automatic test_load_lb;
        in_valid = 1; in_mem_to_reg = 1; in_reg_write = 1; in_funct3 = 3'd0; in_rd = 12;
        in_alu_result = 64'h1003; mem_rdata = 64'h0000_0000_8000_0000;
        tick;
        in_valid = 0; in_mem_to_reg = 0;
        checks++; if ({pend_valid, pend_rd, in_ready} !== {1'b1, 5'd12, 1'b0}) begin errors++; $display("FAIL lb_pend1 got pv=%b prd=%0d rdy=%b want 1/12/0", pend_valid, pend_rd, in_ready); end
        tick; tick;
        checks++; if ({pend_valid, pend_rd, RegWrite, retire} !== {1'b1, 5'd12, 2'b00}) begin errors++; $display("FAIL lb_pend3 got pv=%b prd=%0d rw=%b ret=%b want 1/12/0/0", pend_valid, pend_rd, RegWrite, retire); end
        tick;
        mem_rvalid = 1;
        tick;
        mem_rvalid = 0;
        checks++; if ({RegWrite, rd, write_data, retire, err} !== {1'b1, 5'd12, 64'hFFFF_FFFF_FFFF_FF80, 2'b10}) begin errors++; $display("FAIL lb_write got rw=%b rd=%0d wd=%h ret=%b err=%b want 1/12/ffffffffffffff80/1/0", RegWrite, rd, write_data, retire, err); end
        checks++; if ({pend_valid, pend_rd} !== 6'd0) begin errors++; $display("FAIL lb_pend_clear got pv=%b prd=%0d want 0/0", pend_valid, pend_rd); end
        tick;
    endtask

    task automatic test_lhu_misaligned;
        int lat; logic rw, e; logic [4:0] r; logic [63:0] wd;
        load_txn(3'd5, 5'd7, 3'd6, 64'hBEEF_1234_5678_9ABC, 2, lat, rw, r, wd, e);
        checks++; if ({lat, rw, r, wd, e} !== {32'd3, 1'b1, 5'd7, 64'hBEEF, 1'b0}) begin errors++; $display("FAIL lhu got lat=%0d rw=%b rd=%0d wd=%h err=%b want 3/1/7/beef/0", lat, rw, r, wd, e); end
        load_txn(3'd2, 5'd8, 3'd2, 64'h1, 1, lat, rw, r, wd, e);
        checks++; if ({lat, rw, e} !== {32'd1, 1'b0, 1'b1}) begin errors++; $display("FAIL lw_misaligned got lat=%0d rw=%b err=%b want 1/0/1", lat, rw, e); end
        tick;
    endtask

    task automatic test_timeout;
        int lat; logic rw, e; logic [4:0] r; logic [63:0] wd;
        load_txn(3'd3, 5'd9, 3'd0, 64'h1122_3344_5566_7788, 99, lat, rw, r, wd, e);
        checks++; if ({lat, rw, e} !== {32'd17, 1'b0, 1'b1}) begin errors++; $display("FAIL timeout got lat=%0d rw=%b err=%b want 17/0/1", lat, rw, e); end
        tick;
        checks++; if ({in_ready, retire, err, pend_valid} !== 4'b1000) begin errors++; $display("FAIL timeout_idle got rdy=%b ret=%b err=%b pv=%b want 1/0/0/0", in_ready, retire, err, pend_valid); end
        load_txn(3'd3, 5'd9, 3'd0, 64'h1122_3344_5566_7788, 16, lat, rw, r, wd, e);
        checks++; if ({lat, rw, wd, e} !== {32'd17, 1'b1, 64'h1122_3344_5566_7788, 1'b0}) begin errors++; $display("FAIL limit_data got lat=%0d rw=%b wd=%h err=%b want 17/1/1122334455667788/0", lat, rw, wd, e); end
        tick;
    endtask

    task automatic test_rd0_illegal;
        int lat; logic rw, e; logic [4:0] r; logic [63:0] wd;
        in_valid = 1; in_reg_write = 1; in_mem_to_reg = 0; in_rd = 0; in_alu_result = 64'h55;
        tick;
        in_valid = 0;
        checks++; if ({RegWrite, retire} !== 2'b01) begin errors++; $display("FAIL rd0 got rw=%b ret=%b want 0/1", RegWrite, retire); end
        load_txn(3'd7, 5'd3, 3'd0, 64'h0, 1, lat, rw, r, wd, e);
        checks++; if ({lat, rw, e} !== {32'd1, 1'b0, 1'b1}) begin errors++; $display("FAIL f3_111 got lat=%0d rw=%b err=%b want 1/0/1", lat, rw, e); end
        tick;
    endtask

    task automatic test_reset_mid_wait;
        in_valid = 1; in_mem_to_reg = 1; in_funct3 = 3'd3; in_rd = 4; in_alu_result = 64'h0;
        tick;
        in_valid = 0; in_mem_to_reg = 0;
        tick; tick;
        #2 reset = 1;
        #1;
        checks++; if ({RegWrite, retire, pend_valid, in_ready} !== 4'b0001) begin errors++; $display("FAIL rst_mid got rw=%b ret=%b pv=%b rdy=%b want 0/0/0/1", RegWrite, retire, pend_valid, in_ready); end
        tick;
        reset = 0;
        mem_rvalid = 1; mem_rdata = 64'hDEAD;
        tick;
        mem_rvalid = 0;
        checks++; if ({RegWrite, retire, pend_valid, in_ready} !== 4'b0001) begin errors++; $display("FAIL rst_after got rw=%b ret=%b pv=%b rdy=%b want 0/0/0/1", RegWrite, retire, pend_valid, in_ready); end
    endtask

    task automatic test_random;
        int lat, dly; logic rw, e, wr; logic [4:0] r, rr; logic [63:0] wd, v; logic [2:0] f3, off;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                rr = 5'($urandom); v = {$urandom, $urandom}; wr = 1'($urandom);
                in_valid = 1; in_mem_to_reg = 0; in_reg_write = wr; in_rd = rr; in_alu_result = v;
                tick;
                in_valid = 0;
                checks++; if ({RegWrite, retire, err} !== {wr && rr != 0, 2'b10} || (wr && rr != 0 && {rd, write_data} !== {rr, v})) begin errors++; $display("FAIL rand_alu%0d got rw=%b rd=%0d wd=%h want rw=%b rd=%0d wd=%h", i, RegWrite, rd, write_data, wr && rr != 0, rr, v); end
            end else begin
                f3 = 3'($urandom); off = 3'($urandom); rr = 5'($urandom); v = {$urandom, $urandom};
                if ($urandom_range(0, 3) == 0) off = 3'd0;
                dly = $urandom_range(1, 18);
                load_txn(f3, rr, off, v, dly, lat, rw, r, wd, e);
                if (!load_legal(f3, off)) begin
                    checks++; if ({lat, rw, e} !== {32'd1, 2'b01}) begin errors++; $display("FAIL rand_illegal%0d f3=%0d off=%0d got lat=%0d rw=%b err=%b want 1/0/1", i, f3, off, lat, rw, e); end
                end else if (dly > 16) begin
                    checks++; if ({lat, rw, e} !== {32'd17, 2'b01}) begin errors++; $display("FAIL rand_timeout%0d got lat=%0d rw=%b err=%b want 17/0/1", i, lat, rw, e); end
                end else begin
                    checks++; if ({lat, rw, e} !== {dly + 1, rr != 0, 1'b0} || (rr != 0 && {r, wd} !== {rr, load_model(f3, off, v)})) begin errors++; $display("FAIL rand_load%0d f3=%0d off=%0d got lat=%0d rw=%b rd=%0d wd=%h want lat=%0d rd=%0d wd=%h", i, f3, off, lat, rw, r, wd, dly + 1, rr, load_model(f3, off, v)); end
                end
            end
            if ($urandom_range(0, 1) == 0) tick;
        end
    endtask

    initial begin
        test_reset;
        test_alu_back_to_back;
        test_load_lb;
        test_lhu_misaligned;
        test_timeout;
        test_rd0_illegal;
        test_reset_mid_wait;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
